// File: rtl/multi_dac_pkg.sv
// Shared types and helpers for the multi-channel behavioural DAC model.
// Provides the channel state enum, code-to-voltage conversion and port sizing.
package multi_dac_pkg;

  localparam int MAX_CODE_WIDTH = 24;

  typedef enum logic {
    SETTLED,
    RAMP
  } dac_state_t;

  function automatic real code_to_volts(
    input logic [MAX_CODE_WIDTH-1:0] code,
    input int                        width,
    input real                       vref
  );
    return real'(code) * vref / real'(64'd1 << width);
  endfunction

  // Channel select needs at least one bit, even for a single channel.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_channel.sv
// One DAC output: latches start/target on load and ramps linearly to target.
// Ports: clk, rst_n (sync, active-low), load, target -> vout (real), settled.
module dac_channel
  import multi_dac_pkg::*;
#(
  parameter int RAMP_CYCLES = 8
)(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  real  target,
  output real  vout,
  output logic settled
);

  localparam int KW = $clog2(RAMP_CYCLES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(RAMP_CYCLES);

  dac_state_t    state, state_n;
  real           start_q, start_n;
  real           tgt_q, tgt_n;
  real           v_q, v_n;
  logic [KW-1:0] k_q, k_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SETTLED;
      start_q <= 0.0;
      tgt_q   <= 0.0;
      v_q     <= 0.0;
      k_q     <= '0;
    end else begin
      state   <= state_n;
      start_q <= start_n;
      tgt_q   <= tgt_n;
      v_q     <= v_n;
      k_q     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    start_n = start_q;
    tgt_n   = tgt_q;
    v_n     = v_q;
    k_n     = k_q;
    if (load) begin
      // Retarget from wherever the output is now: no step.
      state_n = RAMP;
      start_n = v_q;
      tgt_n   = target;
      k_n     = '0;
    end else begin
      unique case (state)
        SETTLED: begin
        end
        RAMP: begin
          k_n = k_q + 1'b1;
          if (k_n == K_LAST) begin
            // Land exactly on target, no interpolation residue.
            v_n     = tgt_q;
            state_n = SETTLED;
          end else begin
            v_n = start_q + (tgt_q - start_q)
                  * real'(k_n) / real'(RAMP_CYCLES);
          end
        end
        default: state_n = SETTLED;
      endcase
    end
  end

  assign vout    = v_q;
  assign settled = (state == SETTLED);

endmodule

// File: rtl/multi_dac_model.sv
// Multi-channel behavioural DAC: write port, decode/broadcast, N ramping outputs.
// Ports: clk, rst_n (sync, active-low), wr_valid/wr_ready, wr_broadcast,
// wr_channel, wr_code -> vout[N] (real), settled[N], busy.
// Define MULTI_DAC_MODEL_CHECKS_EN to enable usage assertions.
module multi_dac_model
  import multi_dac_pkg::*;
#(
  parameter int  N_CHANNELS  = 4,
  parameter int  CODE_WIDTH  = 10,
  parameter real VREF        = 3.3,
  parameter int  RAMP_CYCLES = 8
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            wr_broadcast,
  input  logic [ch_bits(N_CHANNELS)-1:0]  wr_channel,
  input  logic [CODE_WIDTH-1:0]           wr_code,
  output real                             vout [N_CHANNELS],
  output logic [N_CHANNELS-1:0]           settled,
  output logic                            busy
);

  logic                  accept;
  logic [N_CHANNELS-1:0] load;
  real                   target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ready <= 1'b0;
    end else begin
      wr_ready <= 1'b1;
    end
  end

  assign accept = wr_valid & wr_ready;

  always_comb begin
    target = code_to_volts(MAX_CODE_WIDTH'(wr_code),
                           CODE_WIDTH, VREF);
  end

  // Out-of-range channels match no decode line and are dropped.
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    assign load[i] = accept &&
      (wr_broadcast || (32'(wr_channel) == i));

    dac_channel #(
      .RAMP_CYCLES(RAMP_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[i]),
      .target (target),
      .vout   (vout[i]),
      .settled(settled[i])
    );
  end

  assign busy = |(~settled);

`ifdef MULTI_DAC_MODEL_CHECKS_EN
  if (RAMP_CYCLES < 1) begin : g_bad_ramp
    $error("RAMP_CYCLES must be >= 1");
  end
  if (CODE_WIDTH < 1 || CODE_WIDTH > MAX_CODE_WIDTH) begin : g_bad_cw
    $error("CODE_WIDTH must be 1..24");
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_valid) begin
      assert (wr_ready)
        else $error("write while wr_ready=0");
      if (!wr_broadcast) begin
        assert (32'(wr_channel) < N_CHANNELS)
          else $error("wr_channel %0d out of range", wr_channel);
      end
    end
  end
`endif

endmodule
